alu_seq: RTL and testbench
==========================

ALU_SEQ -- requirements
Module: alu_seq

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, operand and result width, legal values 4..32.
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst, input, 1, reset; synchronous and active-high.
REQ-004 The block SHALL have port start, input, 1, request to begin an operation; sampled only in IDLE.
REQ-005 The block SHALL have port op, input, 4, operation code, captured with start.
REQ-006 The block SHALL have ports a and b, input, WIDTH each, operands, captured with start.
REQ-007 The block SHALL have port out, output, WIDTH, registered result.
REQ-008 The block SHALL have ports cy, z, n, ov, output, 1 each, registered flags: carry/borrow, zero, sign (out MSB), signed overflow.
REQ-009 The block SHALL have port busy, output, 1, high while a multi-cycle operation runs.
REQ-010 The block SHALL have port done, output, 1, one-cycle pulse marking that out and the flags have just been updated.

Function
REQ-011 The op encoding SHALL be: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 NOT a, 6 PASS b, 7 ADC (a+b+cy), 8 SBB (a-b-cy), 9 SHL a by b, 10 SHR (logical) a by b, 11 MUL; codes 12..15 SHALL act as PASS b.
REQ-012 The FSM SHALL have two states, IDLE and EXEC; it SHALL reset to IDLE.
REQ-013 Single-cycle ops (0..8, 12..15, and shifts with b=0) SHALL register out/flags at the edge that samples start in IDLE; done SHALL be high for the following cycle only; the FSM stays in IDLE; busy stays 0.
REQ-014 For multi-cycle ops, the edge sampling start SHALL capture the operands, enter EXEC and set busy; N further edges SHALL perform the iterations; the Nth edge SHALL update out/flags, pulse done, clear busy and return to IDLE.
REQ-015 For SHL/SHR, N SHALL be min(b, WIDTH), one bit position per cycle; b >= WIDTH SHALL give out=0; cy = last bit shifted out (0 when b=0).
REQ-016 For MUL, N SHALL be exactly WIDTH (shift-add); out = low WIDTH bits of the 2*WIDTH product; cy = ov = OR of the high WIDTH bits.
REQ-017 ADD/ADC: cy = carry out of bit WIDTH-1; SUB/SBB: cy = 1 when a borrow occurs (unsigned a < b + cy_in); ov = two's-complement overflow for these four ops.
REQ-018 For logic, NOT, PASS and shift ops, ov SHALL be 0; logic, NOT and PASS ops SHALL set cy = 0.
REQ-019 z SHALL be 1 when the new out is 0 and n SHALL equal the new out[WIDTH-1], for every op.
REQ-020 The outputs out, cy, z, n and ov SHALL change only on the edge that raises done and SHALL hold their values otherwise.
REQ-021 ADC/SBB SHALL use the cy value held at the start edge.
REQ-022 A start asserted while busy is high SHALL be ignored without side effects; the op in progress SHALL be unaffected.
REQ-023 A start sampled in the cycle in which done is high SHALL be accepted (back-to-back operation, no dead cycle).

Reset
REQ-024 When rst is high at a rising edge, the block SHALL set out=0, cy=z=n=ov=0, busy=0, done=0 and state=IDLE, overriding start.
REQ-025 A reset during EXEC SHALL abort the operation with no done pulse; the next start after reset SHALL behave normally.

Verification (WIDTH=8)
REQ-026 The bench SHALL cover ADD: a=0xFF, b=0x01, start pulse -> the next cycle shows out=0x00, cy=1, z=1, n=0, ov=0, done=1 for one cycle, and busy=0 throughout.
REQ-027 The bench SHALL cover SUB then ADC: SUB a=0x02, b=0x0A -> out=0xF8, cy=1, n=1; then immediately ADC a=0x01, b=0x01 -> out=0x03, cy=0.
REQ-028 The bench SHALL cover SHL: a=0x81, b=3 -> busy high for 3 cycles, then out=0x08, cy=0, done pulse on the 3rd iteration edge; also b=9 -> out=0x00, z=1 after 8 cycles.
REQ-029 The bench SHALL cover MUL: a=0x10, b=0x20 -> done after exactly 8 iteration edges with out=0x00, cy=1, ov=1, z=1; also a=0x0F, b=0x0F -> out=0xE1, cy=0.
REQ-030 The bench SHALL cover a start during busy: MUL in progress, start with ADD at iteration 3 -> ignored; the MUL result is unchanged and only one done pulse occurs.
REQ-031 The bench SHALL cover reset mid-operation: rst high at MUL iteration 4 -> next cycle busy=0, done=0, out=0, all flags 0; no done pulse follows.

Source files
------------

// File: rtl/alu_seq.sv
// Sequential ALU: single-cycle arithmetic/logic ops, iterative shifts
// (one bit per cycle) and a shift-add multiplier. Results and flags are
// registered and announced by a one-cycle done pulse.
module alu_seq #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] out,
  output logic             cy,
  output logic             z,
  output logic             n,
  output logic             ov,
  output logic             busy,
  output logic             done
);

  localparam int CW  = $clog2(WIDTH + 1);
  localparam int MSB = WIDTH - 1;

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_AND = 4'd2;
  localparam logic [3:0] OP_OR  = 4'd3;
  localparam logic [3:0] OP_XOR = 4'd4;
  localparam logic [3:0] OP_NOT = 4'd5;
  localparam logic [3:0] OP_ADC = 4'd7;
  localparam logic [3:0] OP_SBB = 4'd8;
  localparam logic [3:0] OP_SHL = 4'd9;
  localparam logic [3:0] OP_SHR = 4'd10;
  localparam logic [3:0] OP_MUL = 4'd11;

  typedef enum logic {IDLE, EXEC} state_t;
  typedef enum logic [1:0] {K_SHL, K_SHR, K_MUL} kind_t;

  state_t             state_q, state_d;
  kind_t              kind_q, kind_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   mcand_q, mcand_d;
  logic [WIDTH-1:0]   out_q, out_d;
  logic               cy_q, cy_d, z_q, z_d, n_q, n_d, ov_q, ov_d;
  logic               done_q, done_d;

  logic               cin;
  logic [WIDTH:0]     sum, diff;
  logic [WIDTH-1:0]   resVal;
  logic               resCy, resOv;

  logic [WIDTH-1:0]   mulAddend;
  logic [WIDTH:0]     mulSum;
  logic [2*WIDTH-1:0] stepAcc;
  logic               stepCy;

  logic               wrEn, wrCy, wrOv;
  logic [WIDTH-1:0]   wrVal;
  logic [WIDTH:0]     bExt;

  // Single-cycle datapath; the carry chain for ADC/SBB uses the held cy flag
  always_comb begin
    cin    = (op == OP_ADC || op == OP_SBB) ? cy_q : 1'b0;
    sum    = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
    diff   = {1'b0, a} - {1'b0, b} - {{WIDTH{1'b0}}, cin};
    resVal = b;
    resCy  = 1'b0;
    resOv  = 1'b0;
    case (op)
      OP_ADD, OP_ADC: begin
        resVal = sum[WIDTH-1:0];
        resCy  = sum[WIDTH];
        resOv  = (a[MSB] == b[MSB]) && (sum[MSB] != a[MSB]);
      end
      OP_SUB, OP_SBB: begin
        resVal = diff[WIDTH-1:0];
        resCy  = diff[WIDTH];
        resOv  = (a[MSB] != b[MSB]) && (diff[MSB] != a[MSB]);
      end
      OP_AND:         resVal = a & b;
      OP_OR:          resVal = a | b;
      OP_XOR:         resVal = a ^ b;
      OP_NOT:         resVal = ~a;
      OP_SHL, OP_SHR: resVal = a;
      default:        resVal = b;
    endcase
  end

  // One iteration of the running shift or shift-add multiply
  always_comb begin
    mulAddend = acc_q[0] ? mcand_q : {WIDTH{1'b0}};
    mulSum    = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, mulAddend};
    case (kind_q)
      K_SHL: begin
        stepAcc = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-2:0], 1'b0};
        stepCy  = acc_q[WIDTH-1];
      end
      K_SHR: begin
        stepAcc = {acc_q[2*WIDTH-1:WIDTH], 1'b0, acc_q[WIDTH-1:1]};
        stepCy  = acc_q[0];
      end
      default: begin
        stepAcc = {mulSum, acc_q[WIDTH-1:1]};
        stepCy  = 1'b0;
      end
    endcase
  end

  // Next-state logic: accept start in IDLE, iterate in EXEC, write results
  always_comb begin
    state_d = state_q;
    kind_d  = kind_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    mcand_d = mcand_q;
    out_d   = out_q;
    cy_d    = cy_q;
    z_d     = z_q;
    n_d     = n_q;
    ov_d    = ov_q;
    done_d  = 1'b0;
    wrEn    = 1'b0;
    wrVal   = resVal;
    wrCy    = resCy;
    wrOv    = resOv;
    bExt    = {1'b0, b};
    case (state_q)
      IDLE: begin
        if (start) begin
          if (op == OP_MUL) begin
            state_d = EXEC;
            kind_d  = K_MUL;
            cnt_d   = CW'(WIDTH);
            acc_d   = {{WIDTH{1'b0}}, b};
            mcand_d = a;
          end else if ((op == OP_SHL || op == OP_SHR) && (b != '0)) begin
            state_d = EXEC;
            kind_d  = (op == OP_SHL) ? K_SHL : K_SHR;
            cnt_d   = (bExt >= (WIDTH+1)'(WIDTH)) ? CW'(WIDTH) : CW'(b);
            acc_d   = {{WIDTH{1'b0}}, a};
          end else begin
            wrEn = 1'b1;
          end
        end
      end
      EXEC: begin
        acc_d = stepAcc;
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          state_d = IDLE;
          wrEn    = 1'b1;
          wrVal   = stepAcc[WIDTH-1:0];
          if (kind_q == K_MUL) begin
            wrCy = |stepAcc[2*WIDTH-1:WIDTH];
            wrOv = |stepAcc[2*WIDTH-1:WIDTH];
          end else begin
            wrCy = stepCy;
            wrOv = 1'b0;
          end
        end
      end
    endcase
    if (wrEn) begin
      out_d  = wrVal;
      cy_d   = wrCy;
      ov_d   = wrOv;
      z_d    = (wrVal == '0);
      n_d    = wrVal[MSB];
      done_d = 1'b1;
    end
  end

  // State and result registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      kind_q  <= K_SHL;
      cnt_q   <= '0;
      acc_q   <= '0;
      mcand_q <= '0;
      out_q   <= '0;
      cy_q    <= 1'b0;
      z_q     <= 1'b0;
      n_q     <= 1'b0;
      ov_q    <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      kind_q  <= kind_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      mcand_q <= mcand_d;
      out_q   <= out_d;
      cy_q    <= cy_d;
      z_q     <= z_d;
      n_q     <= n_d;
      ov_q    <= ov_d;
      done_q  <= done_d;
    end
  end

  assign out  = out_q;
  assign cy   = cy_q;
  assign z    = z_q;
  assign n    = n_q;
  assign ov   = ov_q;
  assign done = done_q;
  assign busy = (state_q == EXEC);

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq at WIDTH=8: a table of operations run
// back-to-back through a result scoreboard, then hand-written sequences
// for start-while-busy and reset in the middle of a multiply.
module tb_alu_seq;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst, start;
  logic [3:0]   op;
  logic [W-1:0] a, b, out;
  logic         cy, z, n, ov, busy, done;

  typedef struct {
    logic [7:0] out;
    logic       cy, z, n, ov;
  } expT;

  typedef struct {
    logic [3:0] op;
    logic [7:0] a, b, eOut;
    logic       eCy, eOv;
    int         eLat;
  } vecT;

  expT sb[$];
  vecT vecs[24];
  int  testsRun = 0;
  int  testsFailed = 0;
  int  doneCount = 0;

  alu_seq #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
    .out(out), .cy(cy), .z(z), .n(n), .ov(ov), .busy(busy), .done(done)
  );

  // Free-running clock, 10 time units per cycle
  always #5 clk = ~clk;

  // Count every done pulse, sampled on the falling edge
  always @(negedge clk) begin
    if (done === 1'b1) doneCount++;
  end

  // Hard stop if anything waits forever
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
    testsRun++;
    if (act !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Pop the oldest expected result and compare it with the DUT outputs
  task automatic checkOutput(input string name);
    expT e;
    if (sb.size() == 0) begin
      testsRun++;
      testsFailed++;
      $display("[TB] FAIL %s: done with empty scoreboard", name);
    end else begin
      e = sb.pop_front();
      checkVal({name, " {out,cy,z,n,ov}"}, {20'd0, out, cy, z, n, ov},
               {20'd0, e.out, e.cy, e.z, e.n, e.ov});
    end
  endtask

  task automatic pushExp(input logic [7:0] eOut, input logic eCy, input logic eOv);
    expT e;
    e.out = eOut;
    e.cy  = eCy;
    e.z   = (eOut == 8'h00);
    e.n   = eOut[7];
    e.ov  = eOv;
    sb.push_back(e);
  endtask

  // Drive one operation, wait for done, check result, latency and busy
  task automatic applyStimulus(input logic [3:0] opV, input logic [7:0] aV, input logic [7:0] bV,
                               input logic [7:0] eOut, input logic eCy, input logic eOv,
                               input int eLat, input string name);
    int         lat;
    logic       busyOk;
    logic [7:0] held;
    pushExp(eOut, eCy, eOv);
    held  = out;
    start = 1'b1;
    op    = opV;
    a     = aV;
    b     = bV;
    tick();
    start  = 1'b0;
    lat    = 0;
    busyOk = 1'b1;
    while (done !== 1'b1 && lat < 40) begin
      if (busy !== 1'b1 || out !== held) busyOk = 1'b0;
      tick();
      lat++;
    end
    if (done !== 1'b1) begin
      testsRun++;
      testsFailed++;
      $display("[TB] FAIL %s timeout: no done within 40 cycles", name);
      void'(sb.pop_front());
    end else begin
      checkOutput(name);
      checkVal({name, " latency"}, lat, eLat);
      checkVal({name, " busy/hold while running"}, {31'd0, busyOk}, 32'd1);
      checkVal({name, " busy at done"}, {31'd0, busy}, 32'd0);
    end
  endtask

  initial begin
    int lat;
    int doneBefore;

    rst   = 1'b1;
    start = 1'b0;
    op    = 4'd0;
    a     = 8'h00;
    b     = 8'h00;

    //            op     a      b      out    cy    ov    lat
    vecs = '{
      '{4'd0,  8'hFF, 8'h01, 8'h00, 1'b1, 1'b0, 0},
      '{4'd1,  8'h02, 8'h0A, 8'hF8, 1'b1, 1'b0, 0},
      '{4'd7,  8'h01, 8'h01, 8'h03, 1'b0, 1'b0, 0},
      '{4'd0,  8'h7F, 8'h01, 8'h80, 1'b0, 1'b1, 0},
      '{4'd1,  8'h80, 8'h01, 8'h7F, 1'b0, 1'b1, 0},
      '{4'd1,  8'h00, 8'h01, 8'hFF, 1'b1, 1'b0, 0},
      '{4'd8,  8'h05, 8'h02, 8'h02, 1'b0, 1'b0, 0},
      '{4'd2,  8'hF0, 8'h3C, 8'h30, 1'b0, 1'b0, 0},
      '{4'd3,  8'hF0, 8'h0F, 8'hFF, 1'b0, 1'b0, 0},
      '{4'd4,  8'hAA, 8'hAA, 8'h00, 1'b0, 1'b0, 0},
      '{4'd5,  8'h55, 8'h00, 8'hAA, 1'b0, 1'b0, 0},
      '{4'd6,  8'h11, 8'hC3, 8'hC3, 1'b0, 1'b0, 0},
      '{4'd13, 8'h11, 8'h5A, 8'h5A, 1'b0, 1'b0, 0},
      '{4'd0,  8'h80, 8'h80, 8'h00, 1'b1, 1'b1, 0},
      '{4'd7,  8'h00, 8'h00, 8'h01, 1'b0, 1'b0, 0},
      '{4'd9,  8'hA5, 8'h00, 8'hA5, 1'b0, 1'b0, 0},
      '{4'd10, 8'h81, 8'h01, 8'h40, 1'b1, 1'b0, 1},
      '{4'd9,  8'h81, 8'h03, 8'h08, 1'b0, 1'b0, 3},
      '{4'd9,  8'h81, 8'h09, 8'h00, 1'b1, 1'b0, 8},
      '{4'd10, 8'hF0, 8'h04, 8'h0F, 1'b0, 1'b0, 4},
      '{4'd11, 8'h10, 8'h20, 8'h00, 1'b1, 1'b1, 8},
      '{4'd11, 8'h0F, 8'h0F, 8'hE1, 1'b0, 1'b0, 8},
      '{4'd11, 8'hFF, 8'hFF, 8'h01, 1'b1, 1'b1, 8},
      '{4'd8,  8'h00, 8'h00, 8'hFF, 1'b1, 1'b0, 0}
    };

    // Reset, including a start that must be overridden by reset
    tick();
    tick();
    start = 1'b1;
    op    = 4'd0;
    a     = 8'h05;
    b     = 8'h06;
    tick();
    checkVal("reset out", {24'd0, out}, 32'd0);
    checkVal("reset flags", {28'd0, cy, z, n, ov}, 32'd0);
    checkVal("reset busy", {31'd0, busy}, 32'd0);
    checkVal("reset done", {31'd0, done}, 32'd0);
    start = 1'b0;
    rst   = 1'b0;
    tick();

    // Table of operations, each started in the cycle the previous done is high
    for (int i = 0; i < 24; i++) begin
      applyStimulus(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].eOut, vecs[i].eCy,
                    vecs[i].eOv, vecs[i].eLat, $sformatf("vec%0d op%0d", i, vecs[i].op));
    end

    // Done lasts exactly one cycle and outputs hold afterwards
    tick();
    checkVal("done single pulse", {31'd0, done}, 32'd0);
    checkVal("out holds after done", {24'd0, out}, 32'hFF);

    // Start during a multiply is ignored; only one done pulse appears
    doneBefore = doneCount;
    pushExp(8'hE1, 1'b0, 1'b0);
    start = 1'b1;
    op    = 4'd11;
    a     = 8'h0F;
    b     = 8'h0F;
    tick();
    start = 1'b0;
    tick();
    tick();
    checkVal("busy before ignored start", {31'd0, busy}, 32'd1);
    start = 1'b1;
    op    = 4'd0;
    a     = 8'h01;
    b     = 8'h01;
    tick();
    start = 1'b0;
    lat   = 3;
    while (done !== 1'b1 && lat < 40) begin
      tick();
      lat++;
    end
    if (done !== 1'b1) begin
      testsRun++;
      testsFailed++;
      $display("[TB] FAIL busy-start timeout: no done within 40 cycles");
      void'(sb.pop_front());
    end else begin
      checkOutput("mul with ignored start");
      checkVal("mul with ignored start latency", lat, 8);
    end
    tick();
    checkVal("no second done", {31'd0, done}, 32'd0);
    checkVal("idle after mul", {31'd0, busy}, 32'd0);
    checkVal("mul result kept", {24'd0, out}, 32'hE1);
    checkVal("one done pulse", doneCount - doneBefore, 32'd1);

    // Reset at the fourth multiply iteration aborts with no done pulse
    doneBefore = doneCount;
    start = 1'b1;
    op    = 4'd11;
    a     = 8'h0F;
    b     = 8'h0F;
    tick();
    start = 1'b0;
    tick();
    tick();
    tick();
    rst = 1'b1;
    tick();
    checkVal("abort busy", {31'd0, busy}, 32'd0);
    checkVal("abort done", {31'd0, done}, 32'd0);
    checkVal("abort out", {24'd0, out}, 32'd0);
    checkVal("abort flags", {28'd0, cy, z, n, ov}, 32'd0);
    rst = 1'b0;
    repeat (12) tick();
    checkVal("no done after abort", doneCount - doneBefore, 32'd0);
    checkVal("still idle after abort", {31'd0, busy}, 32'd0);

    // Normal operation after reset
    applyStimulus(4'd0, 8'h03, 8'h04, 8'h07, 1'b0, 1'b0, 0, "add after reset");
    tick();
    checkVal("done cleared after add", {31'd0, done}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
